i2c_textram_target: RTL and testbench
=====================================

# i2c_textram_target

I2C target (slave) that bridges an external I2C controller to the 8-bit text RAM port of the Nios II subsystem. The Nios side drives I2C as a controller and owns the text RAM. This block is the other end of that bus: it answers at a fixed 7-bit address and turns I2C write/read transfers into single-byte text RAM accesses at an auto-incrementing 13-bit pointer. It sits in the FPGA top level between the I2C pads and the system's textram slave port.

## Interface

**Parameters**
- `I2C_ADDR`, default 7'h50: 7-bit target address.
- `FILT_LEN`, default 3: number of consecutive equal synchronized samples needed to accept an SCL/SDA level change.

**Ports**
- `clk_clk` in 1: system clock; must be ≥ 20× the SCL frequency.
- `reset_reset_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `scl_in` in 1: SCL pad input.
- `sda_in` in 1: SDA pad input.
- `scl_oe` out 1: SCL pull-low enable; constant 0 (no clock stretching).
- `sda_oe` out 1: SDA pull-low enable; 1 drives the line low.
- `textram_address` out 13: text RAM byte address.
- `textram_chipselect` out 1: access strobe.
- `textram_clken` out 1: RAM clock enable, asserted together with chipselect.
- `textram_write` out 1: 1 = write, 0 = read.
- `textram_writedata` out 8: write byte.
- `textram_readdata` in 8: read byte, valid 2 clocks after a read strobe.

## Operation

**Input conditioning**
- SCL and SDA each pass through a 2-flop synchronizer, then a `FILT_LEN` majority-hold filter.
- Edge detectors on the filtered signals:
  - START = SDA falls while SCL is high.
  - STOP = SDA rises while SCL is high.

**State machine**
- States: IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK, WDATA, WDATA_ACK, RPREP, RDATA, RDATA_ACK, WAIT_STOP.
- START from any state → ADDR with bit counter = 0. This covers repeated START.
- STOP from any state → IDLE.
- Bits are shifted in MSB first on SCL rising edges. After 8 bits the FSM enters the matching _ACK state.
- ADDR_ACK:
  - On address match, drive ACK (`sda_oe`=1) from the next SCL fall to the following SCL fall.
  - R/W=0 → PTR_HI. R/W=1 → RPREP.
  - On mismatch, release SDA and go to WAIT_STOP.
- PTR_HI: byte bits[4:0] load pointer[12:8]; bits[7:5] are ignored. Then ACK → PTR_LO.
- PTR_LO: byte loads pointer[7:0]. Then ACK → WDATA.
- WDATA: on the 8th bit, issue a one-clock write strobe with address = pointer and writedata = byte. Then pointer += 1, ACK, and stay in WDATA.
- RPREP:
  - Issue a one-clock read strobe at pointer.
  - Capture `textram_readdata` 2 clocks later into the shift register.
  - Pointer += 1, then → RDATA.
- RDATA: shift the byte out MSB first. Each bit is placed on SDA right after an SCL fall; `sda_oe` = ~bit.
- RDATA_ACK:
  - Release SDA and sample the controller's bit on SCL rise.
  - ACK (0) → RPREP, then the next byte.
  - NACK (1) → WAIT_STOP.

**Pointer rules**
- The pointer is 13-bit and wraps from 8191 to 0.
- It keeps its value across transactions. A read-only transaction continues from the last pointer.
- A write with only PTR_HI/PTR_LO bytes and no data just sets the pointer.

## Timing

**Reset values**
- All outputs 0.
- FSM in IDLE, pointer 0, shift register 0.

**Bus timing**
- SDA changes happen 1–2 clocks after the filtered SCL fall, i.e. sync + filter + 1 register stage. Total delay ≤ `FILT_LEN`+4 clocks after the pad edge.
- Write latency: the strobe occurs within 2 clocks of the filtered 8th SCL rise.
- Read prefetch completes within 4 clocks. This fits inside SCL low time given the 20× clock ratio.

**Strobe rules**
- `textram_chipselect` = `textram_clken` = 1 for exactly one clock per access.
- Never more than one access per byte.

**Boundary conditions**
- A START or STOP in the middle of a byte aborts the byte. No write strobe is issued and the pointer is unchanged.
- Reset asserted mid-transfer releases SDA immediately (asynchronous).
- A transfer addressed to another target produces no strobes and leaves SDA released.
- A glitch shorter than `FILT_LEN` clocks is ignored.

## Test plan

1. **Write three bytes.** Send START, 0xA0, 0x01, 0x23, 0x41, 0x42, 0x43, STOP.
   - Expect ACK on all six bytes.
   - Expect write strobes at 0x0123/0x0124/0x0125 with data 0x41/0x42/0x43.
   - Final pointer = 0x0126.
2. **Write-then-read.** Send START, 0xA0, 0x1F, 0xFF, repeated START, 0xA1, read 2 bytes with ACK then NACK, STOP. RAM model holds 0x55 at 0x1FFF and 0x66 at 0x0000.
   - Expect read strobes at 0x1FFF then 0x0000.
   - Expect SDA to return 0x55, 0x66 (wrap).
3. **Address mismatch.** Send START, 0xB0, 0x00.
   - Expect SDA released on the ACK slot (NACK).
   - Expect no textram strobes until STOP.
4. **Aborted byte.** Send a write with pointer bytes 0x00, 0x10, then 4 data bits followed by STOP.
   - Expect no write strobe.
   - Pointer stays 0x0010.
   - A subsequent read returns RAM[0x0010].
5. **Reset and glitch handling.**
   - Assert `reset_reset_n`=0 while the target is driving an ACK: expect `sda_oe` = 0 asynchronously and all outputs 0.
   - Inject a 1-clock SDA glitch while SCL is high: expect no false START/STOP.

Source files
------------

// File: rtl/i2c_textram_target_if.sv
// i2c_textram_target_if -- 8-bit text RAM access port.
//   textram_address    : byte address driven by the requester
//   textram_chipselect : one-clock access strobe
//   textram_clken      : RAM clock enable, follows chipselect
//   textram_write      : 1 = write, 0 = read
//   textram_writedata  : write byte
//   textram_readdata   : read byte, valid two clocks after a read strobe
// master = the side issuing accesses (the I2C target), slave = the RAM.
interface i2c_textram_target_if;
   logic [12:0] textram_address;
   logic        textram_chipselect;
   logic        textram_clken;
   logic        textram_write;
   logic [7:0]  textram_writedata;
   logic [7:0]  textram_readdata;

   modport master (
      output textram_address, textram_chipselect, textram_clken,
             textram_write, textram_writedata,
      input  textram_readdata
   );

   modport slave (
      input  textram_address, textram_chipselect, textram_clken,
             textram_write, textram_writedata,
      output textram_readdata
   );
endinterface

// File: rtl/i2c_textram_target.sv
// i2c_textram_target -- I2C target bridging an external controller to the
// text RAM. Answers at I2C_ADDR; a write carries pointer high/low bytes and
// then data bytes, a read streams bytes from the auto-incrementing pointer.
//   clk_clk, reset_reset_n : system clock, async active-low reset
//   scl_in, sda_in         : I2C pad inputs
//   scl_oe                 : SCL pull-low enable (never stretches, always 0)
//   sda_oe                 : SDA pull-low enable (1 drives the line low)
//   textram                : text RAM access port (master side)
module i2c_textram_target #(
   parameter logic [6:0]  I2C_ADDR = 7'h50,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic                 scl_in,
   input  logic                 sda_in,
   output logic                 scl_oe,
   output logic                 sda_oe,
   i2c_textram_target_if.master textram
);
   localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR_HI, PTR_HI_ACK, PTR_LO, PTR_LO_ACK,
      WDATA, WDATA_ACK, RPREP, RDATA, RDATA_ACK, WAIT_STOP
   } state_t;

   // ---- input conditioning: bit 0 = SCL, bit 1 = SDA ----
   logic [1:0]    sync1, sync2, filt, filt_d;
   logic [CW-1:0] fcnt [2];

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1   <= '1;
         sync2   <= '1;
         filt    <= '1;
         filt_d  <= '1;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         sync1  <= {sda_in, scl_in};
         sync2  <= sync1;
         filt_d <= filt;
         // a new level is accepted only after FILT_LEN consecutive samples
         for (int unsigned i = 0; i < 2; i++) begin
            if (sync2[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == CW'(FILT_LEN - 1)) begin
               filt[i] <= sync2[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + CW'(1);
            end
         end
      end
   end

   logic sda_f, scl_rise, scl_fall, start_det, stop_det;
   assign sda_f     = filt[1];
   assign scl_rise  =  filt[0] & ~filt_d[0];
   assign scl_fall  = ~filt[0] &  filt_d[0];
   assign start_det =  filt[0] &  filt_d[0] &  filt_d[1] & ~filt[1];
   assign stop_det  =  filt[0] &  filt_d[0] & ~filt_d[1] &  filt[1];

   // ---- protocol FSM ----
   state_t      state_q, state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d, rx_byte;
   logic [12:0] ptr_q, ptr_d, addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        rw_q, rw_d, sda_oe_q, sda_oe_d, cs_q, cs_d, wr_q, wr_d;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         ptr_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rw_q      <= 1'b0;
         sda_oe_q  <= 1'b0;
         cs_q      <= 1'b0;
         wr_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         ptr_q     <= ptr_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rw_q      <= rw_d;
         sda_oe_q  <= sda_oe_d;
         cs_q      <= cs_d;
         wr_q      <= wr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      ptr_d     = ptr_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rw_d      = rw_q;
      sda_oe_d  = sda_oe_q;
      cs_d      = 1'b0;
      wr_d      = wr_q;
      rx_byte   = {shift_q[6:0], sda_f};

      if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = '0;
         sda_oe_d  = 1'b0;
      end else if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
      end else begin
         unique case (state_q)
            ADDR, PTR_HI, PTR_LO, WDATA: begin
               if (scl_rise) begin
                  shift_d   = rx_byte;
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     case (state_q)
                        ADDR: begin
                           if (rx_byte[7:1] == I2C_ADDR) begin
                              rw_d    = rx_byte[0];
                              state_d = ADDR_ACK;
                           end else begin
                              state_d = WAIT_STOP;
                           end
                        end
                        PTR_HI: begin
                           ptr_d[12:8] = rx_byte[4:0];
                           state_d     = PTR_HI_ACK;
                        end
                        PTR_LO: begin
                           ptr_d[7:0] = rx_byte;
                           state_d    = PTR_LO_ACK;
                        end
                        default: begin
                           cs_d    = 1'b1;
                           wr_d    = 1'b1;
                           addr_d  = ptr_q;
                           wdata_d = rx_byte;
                           ptr_d   = ptr_q + 13'd1;
                           state_d = WDATA_ACK;
                        end
                     endcase
                  end
               end
            end
            // sda_oe_q doubles as the ACK phase: first fall drives, second releases
            ADDR_ACK, PTR_HI_ACK, PTR_LO_ACK, WDATA_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = 1'b1;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     case (state_q)
                        ADDR_ACK:   state_d = rw_q ? RPREP : PTR_HI;
                        PTR_HI_ACK: state_d = PTR_LO;
                        default:    state_d = WDATA;
                     endcase
                  end
               end
            end
            // bit_cnt counts prefetch clocks: strobe at 0, data sampled at 3
            RPREP: begin
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  cs_d   = 1'b1;
                  wr_d   = 1'b0;
                  addr_d = ptr_q;
               end else if (bit_cnt_q == 3'd3) begin
                  shift_d   = textram.textram_readdata;
                  sda_oe_d  = ~textram.textram_readdata[7];
                  ptr_d     = ptr_q + 13'd1;
                  bit_cnt_d = '0;
                  state_d   = RDATA;
               end
            end
            RDATA: begin
               if (scl_fall) begin
                  if (bit_cnt_q == 3'd7) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = '0;
                     state_d   = RDATA_ACK;
                  end else begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     sda_oe_d  = ~shift_q[6];
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end
            end
            // bit_cnt != 0 marks a received ACK; prefetch waits for SCL low
            RDATA_ACK: begin
               if (scl_rise && bit_cnt_q == 3'd0) begin
                  if (sda_f) state_d = WAIT_STOP;
                  else       bit_cnt_d = 3'd1;
               end else if (scl_fall && bit_cnt_q != 3'd0) begin
                  bit_cnt_d = '0;
                  state_d   = RPREP;
               end
            end
            default: ;
         endcase
      end
   end

   assign scl_oe                     = 1'b0;
   assign sda_oe                     = sda_oe_q;
   assign textram.textram_address    = addr_q;
   assign textram.textram_chipselect = cs_q;
   assign textram.textram_clken      = cs_q;
   assign textram.textram_write      = wr_q;
   assign textram.textram_writedata  = wdata_q;
endmodule

// File: tb/tb_i2c_textram_target.sv
// tb_i2c_textram_target -- drives an I2C controller against the target,
// models the text RAM, and scoreboards the RAM accesses and returned bytes
// against a transaction-level reference (pointer + memory image).
module tb_i2c_textram_target;
   localparam int Q = 10;  // clocks per quarter SCL bit period

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n, scl_drv, sda_drv;
   logic scl_in, sda_in, scl_oe, sda_oe;
   assign scl_in = scl_drv & ~scl_oe;
   assign sda_in = sda_drv & ~sda_oe;

   i2c_textram_target_if bus ();

   i2c_textram_target #(.I2C_ADDR(7'h50), .FILT_LEN(3)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .scl_in        (scl_in),
      .sda_in        (sda_in),
      .scl_oe        (scl_oe),
      .sda_oe        (sda_oe),
      .textram       (bus)
   );

   // environment RAM, two-clock read latency
   logic [7:0] ram [8192];
   logic [7:0] rd_pipe = 8'h00;
   always @(posedge clk) begin
      if (bus.textram_chipselect && bus.textram_write)
         ram[bus.textram_address] <= bus.textram_writedata;
      if (bus.textram_chipselect && !bus.textram_write)
         rd_pipe <= ram[bus.textram_address];
      bus.textram_readdata <= rd_pipe;
   end

   // reference model
   logic [7:0] ref_mem [8192];
   int ref_ptr = 0;

   typedef struct {
      bit          wr;
      logic [12:0] addr;
      logic [7:0]  data;
   } acc_t;
   acc_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void check(string name, int act, int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endfunction

   // access monitor
   always @(negedge clk) begin : mon
      acc_t e;
      if (bus.textram_chipselect || bus.textram_clken) begin
         check("clken_eq_cs", bus.textram_clken, bus.textram_chipselect);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL strobe: unexpected access wr=%0d addr=0x%0h, required none",
                     bus.textram_write, bus.textram_address);
         end else begin
            e = exp_q.pop_front();
            check("strobe_wr", bus.textram_write, e.wr);
            check("strobe_addr", bus.textram_address, e.addr);
            if (e.wr) check("strobe_wdata", bus.textram_writedata, e.data);
         end
      end
   end

   // ---- I2C controller ----
   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();  // also serves as repeated START
      sda_drv = 1'b1; wait_clks(Q);
      scl_drv = 1'b1; wait_clks(Q);
      sda_drv = 1'b0; wait_clks(Q);
      scl_drv = 1'b0; wait_clks(Q);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; wait_clks(Q);
      scl_drv = 1'b1; wait_clks(Q);
      sda_drv = 1'b1; wait_clks(2 * Q);
   endtask

   task automatic send_bit(input bit b, input bit glitch);
      sda_drv = b; wait_clks(Q);
      scl_drv = 1'b1; wait_clks(Q);
      if (glitch) begin
         sda_drv = ~b; wait_clks(1);
         sda_drv = b;  wait_clks(Q - 1);
      end else begin
         wait_clks(Q);
      end
      scl_drv = 1'b0; wait_clks(Q);
   endtask

   task automatic recv_bit(output bit b);
      sda_drv = 1'b1; wait_clks(Q);
      scl_drv = 1'b1; wait_clks(Q);
      b = sda_in;     wait_clks(Q);
      scl_drv = 1'b0; wait_clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] v, input int glitch_bit, output bit ack);
      bit b;
      for (int i = 7; i >= 0; i--) send_bit(v[i], i == glitch_bit);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic read_byte(input bit nack, output logic [7:0] v);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         v[i] = b;
      end
      send_bit(nack, 1'b0);
   endtask

   // write transaction: bytes = pointer hi, pointer lo, then data
   task automatic wr_txn(input logic [7:0] ab, input logic [7:0] bytes[$], input bit do_stop);
      bit ack;
      bit match;
      match = (ab[7:1] == 7'h50) && !ab[0];
      i2c_start();
      write_byte(ab, -1, ack);
      check("wr_addr_ack", ack, match);
      foreach (bytes[i]) begin
         if (match) begin
            if (i == 0)      ref_ptr = (ref_ptr % 256) + (bytes[i] % 32) * 256;
            else if (i == 1) ref_ptr = (ref_ptr / 256) * 256 + bytes[i];
            else begin
               exp_q.push_back('{wr: 1'b1, addr: 13'(ref_ptr), data: bytes[i]});
               ref_mem[ref_ptr] = bytes[i];
               ref_ptr = (ref_ptr + 1) % 8192;
            end
         end
         write_byte(bytes[i], -1, ack);
         check("wr_byte_ack", ack, match);
      end
      if (do_stop) begin
         i2c_stop();
         check("wr_strobes_done", exp_q.size(), 0);
      end
   endtask

   task automatic rd_txn(input int n);
      bit ack;
      logic [7:0] v;
      logic [7:0] expv[$];
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{wr: 1'b0, addr: 13'(ref_ptr), data: 8'h00});
         expv.push_back(ref_mem[ref_ptr]);
         ref_ptr = (ref_ptr + 1) % 8192;
      end
      i2c_start();
      write_byte(8'hA1, -1, ack);
      check("rd_addr_ack", ack, 1);
      for (int k = 0; k < n; k++) begin
         read_byte(k == n - 1, v);
         check("rd_data", v, expv[k]);
      end
      i2c_stop();
      check("rd_strobes_done", exp_q.size(), 0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] q[$];
      logic [7:0] v, ph, pl;
      logic [6:0] a7;
      bit ack;
      int sel, w;

      for (int i = 0; i < 8192; i++) begin
         v = 8'($urandom);
         ram[i] = v;
         ref_mem[i] = v;
      end
      ram[13'h1FFF] = 8'h55; ref_mem[13'h1FFF] = 8'h55;
      ram[13'h0000] = 8'h66; ref_mem[13'h0000] = 8'h66;

      scl_drv = 1'b1;
      sda_drv = 1'b1;
      rst_n   = 1'b0;
      wait_clks(5);
      check("rst_sda_oe", sda_oe, 0);
      check("rst_scl_oe", scl_oe, 0);
      check("rst_cs", bus.textram_chipselect, 0);
      check("rst_addr", bus.textram_address, 0);
      check("rst_wdata", bus.textram_writedata, 0);
      rst_n = 1'b1;
      wait_clks(10);

      // three-byte write, then read back from the advanced pointer
      q = '{8'h01, 8'h23, 8'h41, 8'h42, 8'h43};
      wr_txn(8'hA0, q, 1'b1);
      check("ptr_after_write", ref_ptr, 13'h0126);
      rd_txn(1);

      // pointer set to top of RAM, repeated START, read across the wrap
      q = '{8'h1F, 8'hFF};
      wr_txn(8'hA0, q, 1'b0);
      rd_txn(2);

      // another target's address
      q = '{8'h00};
      wr_txn(8'hB0, q, 1'b1);

      // data byte cut short by STOP
      q = '{8'h00, 8'h10};
      wr_txn(8'hA0, q, 1'b0);
      v = 8'hA5;
      for (int i = 7; i >= 4; i--) send_bit(v[i], 1'b0);
      i2c_stop();
      check("abort_no_strobe", exp_q.size(), 0);
      rd_txn(1);

      // one-clock SDA glitches while SCL high (false START and false STOP)
      i2c_start();
      write_byte(8'hA0, 6, ack);  check("glitch_addr_ack", ack, 1);
      write_byte(8'h02, 1, ack);  check("glitch_phi_ack", ack, 1);
      write_byte(8'h00, 4, ack);  check("glitch_plo_ack", ack, 1);
      ref_ptr = 13'h0200;
      exp_q.push_back('{wr: 1'b1, addr: 13'h0200, data: 8'hC5});
      ref_mem[13'h0200] = 8'hC5;
      ref_ptr = 13'h0201;
      write_byte(8'hC5, 7, ack);  check("glitch_data_ack", ack, 1);
      i2c_stop();
      check("glitch_strobes_done", exp_q.size(), 0);

      // reset while the target holds the address ACK
      i2c_start();
      v = 8'hA0;
      for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
      w = 0;
      while (!sda_oe && w < 40) begin
         wait_clks(1);
         w++;
      end
      check("ack_driven_before_reset", sda_oe, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sda_oe", sda_oe, 0);
      check("async_rst_cs", bus.textram_chipselect, 0);
      check("async_rst_clken", bus.textram_clken, 0);
      check("async_rst_write", bus.textram_write, 0);
      check("async_rst_addr", bus.textram_address, 0);
      check("async_rst_wdata", bus.textram_writedata, 0);
      wait_clks(4);
      rst_n = 1'b1;
      wait_clks(2);
      i2c_stop();
      ref_ptr = 0;
      rd_txn(2);

      // randomized transactions
      for (int t = 0; t < 10; t++) begin
         sel = $urandom_range(0, 3);
         if (sel <= 1) begin
            ph = 8'($urandom);
            pl = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
               ph = {3'($urandom), 5'h1F};
               pl = 8'hFE;
            end
            q = '{ph, pl};
            for (int k = 0; k < $urandom_range(0, 3); k++) q.push_back(8'($urandom));
            wr_txn(8'hA0, q, sel == 0);
            if (sel == 1) rd_txn($urandom_range(1, 3));
         end else if (sel == 2) begin
            rd_txn($urandom_range(1, 3));
         end else begin
            a7 = 7'($urandom);
            if (a7 == 7'h50) a7 = 7'h51;
            q = '{8'($urandom), 8'($urandom)};
            wr_txn({a7, 1'b0}, q, 1'b1);
         end
      end

      wait_clks(10);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_scl_oe", scl_oe, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
